uart_periph: RTL and testbench

Memory-mapped 8N1 UART peripheral with one transmitter, one receiver and a programmable baud divisor. It sits on the core's data-memory bus. Writes use uart_wr_enable + uart_addr + wdata_mem. Reads return register contents on uart_data, and read side-effects are qualified by uart_sel.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_baud_tick.sv | 37 +++
 rtl/uart_periph.sv | 261 ++++++++++++++++++++++++++
 tb/tb_uart_periph.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and state types for the uart_periph slice.
// Build option: UART_PARITY_EN adds an even-parity bit between data and stop.
package uart_pkg;

    localparam logic [3:0] ADDR_STATUS = 4'h0;
    localparam logic [3:0] ADDR_TX     = 4'h1;
    localparam logic [3:0] ADDR_RX     = 4'h2;
    localparam logic [3:0] ADDR_BAUD   = 4'h3;

    localparam int ST_TX_BUSY    = 0;
    localparam int ST_RX_VALID   = 1;
    localparam int ST_FRAME_ERR  = 2;
    localparam int ST_OVERRUN    = 3;
    localparam int ST_PARITY_ERR = 4;

    // Bits shifted between start and stop: the data byte, plus parity when enabled.
`ifdef UART_PARITY_EN
    localparam int NDATA = 9;
`else
    localparam int NDATA = 8;
`endif
    localparam logic [3:0] LAST_BIT = 4'(NDATA - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: explicit load sets the first interval, later intervals
// auto-reload from div_i. tick_o pulses for one clock at each interval end.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] load_val_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && !load_i && (cnt_q == '0);

    // Counting down to zero makes the tick land exactly N clocks after a load of N.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i - DIV_W'(1);
        end else if (en_i) begin
            cnt_d = (cnt_q == '0) ? (div_i - DIV_W'(1)) : (cnt_q - DIV_W'(1));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_periph.sv
// Memory-mapped 8N1 UART: TX engine, RX engine with 2-flop synchronizer, baud divisor.
// Build option: UART_PARITY_EN selects an 11-bit frame with even parity.
module uart_periph
    import uart_pkg::*;
#(
    parameter int DEFAULT_DIV = 868,
    parameter int DIV_W       = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_bit,
    output logic        tx_bit,
    input  logic        uart_wr_enable,
    input  logic        uart_sel,
    input  logic [3:0]  uart_addr,
    input  logic [31:0] wdata_mem,
    output logic [31:0] uart_data
);

    logic wr_status, wr_tx, wr_baud, rd_rx;
    logic unused_wdata;

    assign wr_status    = uart_wr_enable && (uart_addr == ADDR_STATUS);
    assign wr_tx        = uart_wr_enable && (uart_addr == ADDR_TX);
    assign wr_baud      = uart_wr_enable && (uart_addr == ADDR_BAUD);
    assign rd_rx        = uart_sel && (uart_addr == ADDR_RX);
    assign unused_wdata = ^wdata_mem;

    logic [DIV_W-1:0] baud_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            baud_q <= DIV_W'(DEFAULT_DIV);
        end else if (wr_baud) begin
            baud_q <= (wdata_mem[DIV_W-1:0] < DIV_W'(2)) ? DIV_W'(2) : wdata_mem[DIV_W-1:0];
        end
    end

    tx_state_t        tx_state_q, tx_state_d;
    logic             tx_q, tx_d;
    logic [NDATA-1:0] tx_shift_q, tx_shift_d, tx_frame;
    logic [3:0]       tx_cnt_q, tx_cnt_d;
    logic [DIV_W-1:0] tx_div_q, tx_div_d;
    logic             tx_load, tx_en, tx_tick;

`ifdef UART_PARITY_EN
    assign tx_frame = {^wdata_mem[7:0], wdata_mem[7:0]};
`else
    assign tx_frame = wdata_mem[7:0];
`endif

    assign tx_en  = (tx_state_q != TX_IDLE);
    assign tx_bit = tx_q;

    uart_baud_tick #(.DIV_W(DIV_W)) u_tx_tick (
        .clk_i      (clock),
        .rst_ni     (reset),
        .load_i     (tx_load),
        .en_i       (tx_en),
        .load_val_i (baud_q),
        .div_i      (tx_div_q),
        .tick_o     (tx_tick)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_d       = tx_q;
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        tx_div_d   = tx_div_q;
        tx_load    = 1'b0;
        case (tx_state_q)
            TX_IDLE: if (wr_tx) begin
                tx_state_d = TX_START;
                tx_d       = 1'b0;
                tx_shift_d = tx_frame;
                tx_div_d   = baud_q;
                tx_load    = 1'b1;
            end
            TX_START: if (tx_tick) begin
                tx_state_d = TX_DATA;
                tx_d       = tx_shift_q[0];
                tx_shift_d = tx_shift_q >> 1;
                tx_cnt_d   = '0;
            end
            TX_DATA: if (tx_tick) begin
                if (tx_cnt_q == LAST_BIT) begin
                    tx_state_d = TX_STOP;
                    tx_d       = 1'b1;
                end else begin
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
                    tx_cnt_d   = tx_cnt_q + 4'd1;
                end
            end
            TX_STOP: if (tx_tick) tx_state_d = TX_IDLE;
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_state_q <= TX_IDLE;
            tx_q       <= 1'b1;
            tx_shift_q <= '0;
            tx_cnt_q   <= '0;
            tx_div_q   <= DIV_W'(DEFAULT_DIV);
        end else begin
            tx_state_q <= tx_state_d;
            tx_q       <= tx_d;
            tx_shift_q <= tx_shift_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
        end
    end

    logic rx_s1_q, rx_s2_q, rx_prev_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx_bit;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    rx_state_t        rx_state_q, rx_state_d;
    logic [NDATA-1:0] rx_shift_q, rx_shift_d;
    logic [3:0]       rx_cnt_q, rx_cnt_d;
    logic [DIV_W-1:0] rx_div_q, rx_div_d, rx_half;
    logic             rx_load, rx_en, rx_tick, rx_deliver;

    assign rx_en   = (rx_state_q != RX_IDLE);
    assign rx_half = baud_q >> 1;

    // First interval is half a bit so every later tick lands mid-bit.
    uart_baud_tick #(.DIV_W(DIV_W)) u_rx_tick (
        .clk_i      (clock),
        .rst_ni     (reset),
        .load_i     (rx_load),
        .en_i       (rx_en),
        .load_val_i (rx_half),
        .div_i      (rx_div_q),
        .tick_o     (rx_tick)
    );

    always_comb begin
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        rx_cnt_d   = rx_cnt_q;
        rx_div_d   = rx_div_q;
        rx_load    = 1'b0;
        rx_deliver = 1'b0;
        case (rx_state_q)
            RX_IDLE: if (rx_prev_q && !rx_s2_q) begin
                rx_state_d = RX_START;
                rx_div_d   = baud_q;
                rx_load    = 1'b1;
            end
            RX_START: if (rx_tick) begin
                rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                rx_cnt_d   = '0;
            end
            RX_DATA: if (rx_tick) begin
                rx_shift_d = {rx_s2_q, rx_shift_q[NDATA-1:1]};
                if (rx_cnt_q == LAST_BIT) rx_state_d = RX_STOP;
                else rx_cnt_d = rx_cnt_q + 4'd1;
            end
            RX_STOP: if (rx_tick) begin
                rx_state_d = RX_IDLE;
                rx_deliver = 1'b1;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_state_q <= RX_IDLE;
            rx_shift_q <= '0;
            rx_cnt_q   <= '0;
            rx_div_q   <= DIV_W'(DEFAULT_DIV);
        end else begin
            rx_state_q <= rx_state_d;
            rx_shift_q <= rx_shift_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_div_q   <= rx_div_d;
        end
    end

    logic       rx_valid_q, rx_valid_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       parity_err;

    // A read on the delivery edge consumes the old byte, so it is not an overrun.
    always_comb begin
        rx_valid_d  = rx_deliver ? 1'b1 : (rd_rx ? 1'b0 : rx_valid_q);
        overrun_d   = (rx_deliver && rx_valid_q && !rd_rx) ? 1'b1
                    : ((wr_status && wdata_mem[ST_OVERRUN]) ? 1'b0 : overrun_q);
        frame_err_d = (rx_deliver && !rx_s2_q) ? 1'b1
                    : ((wr_status && wdata_mem[ST_FRAME_ERR]) ? 1'b0 : frame_err_q);
        rx_data_d   = rx_deliver ? rx_shift_q[7:0] : rx_data_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            rx_data_q   <= '0;
        end else begin
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            rx_data_q   <= rx_data_d;
        end
    end

`ifdef UART_PARITY_EN
    logic parity_err_q, parity_err_d;

    // Even parity: data plus parity bit must XOR to zero.
    assign parity_err_d = (rx_deliver && (^rx_shift_q)) ? 1'b1
                        : ((wr_status && wdata_mem[ST_PARITY_ERR]) ? 1'b0 : parity_err_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) parity_err_q <= 1'b0;
        else        parity_err_q <= parity_err_d;
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    logic [4:0] status;

    always_comb begin
        status                = '0;
        status[ST_TX_BUSY]    = tx_en;
        status[ST_RX_VALID]   = rx_valid_q;
        status[ST_FRAME_ERR]  = frame_err_q;
        status[ST_OVERRUN]    = overrun_q;
        status[ST_PARITY_ERR] = parity_err;
    end

    always_comb begin
        uart_data = '0;
        case (uart_addr)
            ADDR_STATUS: uart_data = 32'(status);
            ADDR_RX:     uart_data = 32'(rx_data_q);
            ADDR_BAUD:   uart_data = 32'(baud_q);
            default:     uart_data = '0;
        endcase
    end

endmodule

// File: tb/tb_uart_periph.sv
// Directed/randomized bench for uart_periph with a frame-level reference model.
module tb_uart_periph;

    logic        clock = 1'b0;
    logic        reset, rx_bit, tx_bit, uart_wr_enable, uart_sel;
    logic [3:0]  uart_addr;
    logic [31:0] wdata_mem, uart_data;

    int n_checks = 0;
    int n_errors = 0;

`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int RX_DIV = 87;

    logic       exp_valid, exp_fe, exp_ovr;
    logic [7:0] exp_data, b, b2;
    int         d1;

    uart_periph dut (
        .clock          (clock),
        .reset          (reset),
        .rx_bit         (rx_bit),
        .tx_bit         (tx_bit),
        .uart_wr_enable (uart_wr_enable),
        .uart_sel       (uart_sel),
        .uart_addr      (uart_addr),
        .wdata_mem      (wdata_mem),
        .uart_data      (uart_data)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic rd_check(input logic [3:0] a, input logic [31:0] exp, input string tag);
        uart_addr = a;
        #1;
        check(tag, uart_data, exp);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        uart_wr_enable = 1'b1;
        uart_addr      = a;
        wdata_mem      = d;
        cyc(1);
        uart_wr_enable = 1'b0;
    endtask

    task automatic rd_clear();
        uart_sel  = 1'b1;
        uart_addr = 4'h2;
        cyc(1);
        uart_sel  = 1'b0;
        exp_valid = 1'b0;
    endtask

    // Frame bit k of a byte: start, data LSB first, optional even parity, stop.
    function automatic logic fbit(input logic [7:0] v, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return v[k-1];
`ifdef UART_PARITY_EN
        if (k == 9) return ^v;
`endif
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_status();
        return {27'b0, 1'b0, exp_ovr, exp_fe, exp_valid, 1'b0};
    endfunction

    // Write TX_DATA, then check line level and busy at the first and last clock of every bit.
    task automatic tx_check(input logic [7:0] v, input int div, input int inj_c,
                            input logic [3:0] inj_a, input logic [31:0] inj_d);
        uart_wr_enable = 1'b1;
        uart_addr      = 4'h1;
        wdata_mem      = {24'b0, v};
        for (int c = 0; c <= NB * div; c++) begin
            cyc(1);
            uart_wr_enable = 1'b0;
            uart_addr      = 4'h0;
            #1;
            if (c == NB * div) begin
                check("tx_end_line", 32'(tx_bit), 32'h1);
                check("tx_end_busy", 32'(uart_data[0]), 32'h0);
            end else if ((c % div == 0) || (c % div == div - 1)) begin
                check($sformatf("tx_bit%0d_c%0d", c / div, c), 32'(tx_bit), 32'(fbit(v, c / div)));
                check($sformatf("tx_busy_c%0d", c), 32'(uart_data[0]), 32'h1);
            end
            if (c == inj_c) begin
                uart_wr_enable = 1'b1;
                uart_addr      = inj_a;
                wdata_mem      = inj_d;
            end
        end
    endtask

    task automatic rx_send(input logic [7:0] v, input logic stop_v);
        for (int k = 0; k < NB; k++) begin
            rx_bit = (k == NB - 1) ? stop_v : fbit(v, k);
            cyc(RX_DIV);
        end
        rx_bit = 1'b1;
        cyc(4);
        if (exp_valid) exp_ovr = 1'b1;
        exp_valid = 1'b1;
        exp_data  = v;
        if (!stop_v) exp_fe = 1'b1;
    endtask

    initial begin
        reset = 1'b0; rx_bit = 1'b1; uart_wr_enable = 1'b0; uart_sel = 1'b0;
        uart_addr = 4'h0; wdata_mem = 32'h0;
        exp_valid = 1'b0; exp_fe = 1'b0; exp_ovr = 1'b0; exp_data = 8'h0;

        cyc(3);
        check("rst_tx_line", 32'(tx_bit), 32'h1);
        rd_check(4'h0, 32'h0, "rst_status");
        rd_check(4'h3, 32'd868, "rst_baud");
        rd_check(4'h2, 32'h0, "rst_rxdata");
        reset = 1'b1;
        cyc(2);

        wr(4'h3, 32'h1);
        rd_check(4'h3, 32'd2, "baud_clamp1");
        wr(4'h3, 32'h0);
        rd_check(4'h3, 32'd2, "baud_clamp0");
        wr(4'h3, 32'hFFFF_0057);
        rd_check(4'h3, 32'd87, "baud_87");
        rd_check(4'h1, 32'h0, "txdata_reads0");
        rd_check(4'h9, 32'h0, "unmapped_reads0");

        tx_check(8'h41, 87, 200, 4'h1, 32'h55);

        d1 = int'($urandom_range(8, 30));
        b  = 8'($urandom);
        b2 = 8'($urandom);
        wr(4'h3, 32'(d1));
        tx_check(b, d1, 5, 4'h3, 32'(d1 + 7));
        rd_check(4'h3, 32'(d1 + 7), "baud_midframe_write");
        tx_check(b2, d1 + 7, -1, 4'h0, 32'h0);

        wr(4'h3, 32'(RX_DIV));
        rx_send(8'hA5, 1'b1);
        rd_check(4'h0, exp_status(), "rx_a5_status");
        rd_check(4'h2, 32'(exp_data), "rx_a5_data");
        wr(4'h0, 32'h3);
        rd_check(4'h0, exp_status(), "w1c_low_bits_ignored");
        rd_clear();
        rd_check(4'h0, exp_status(), "rx_read_clears_valid");

        b = 8'($urandom);
        rx_send(b, 1'b0);
        rd_check(4'h0, exp_status(), "rx_frame_err_status");
        rd_check(4'h2, 32'(exp_data), "rx_frame_err_data");
        wr(4'h0, 32'h4);
        exp_fe = 1'b0;
        rd_check(4'h0, exp_status(), "w1c_frame_err");
        rd_clear();

        b  = 8'($urandom);
        b2 = 8'($urandom);
        rx_send(b, 1'b1);
        rx_send(b2, 1'b1);
        rd_check(4'h0, exp_status(), "rx_overrun_status");
        rd_check(4'h2, 32'(b2), "rx_overrun_data");
        wr(4'h0, 32'h8);
        exp_ovr = 1'b0;
        rd_check(4'h0, exp_status(), "w1c_overrun");
        rd_clear();
        rd_check(4'h0, exp_status(), "rx_cleared_before_glitch");

        rx_bit = 1'b0;
        cyc(RX_DIV / 4);
        rx_bit = 1'b1;
        cyc(200);
        rd_check(4'h0, exp_status(), "glitch_no_valid");
        rd_check(4'h2, 32'(exp_data), "glitch_data_kept");

        wr(4'h1, 32'h3C);
        cyc(100);
        #2;
        reset = 1'b0;
        #1;
        check("midframe_rst_tx_line", 32'(tx_bit), 32'h1);
        rd_check(4'h0, 32'h0, "midframe_rst_status");
        rd_check(4'h3, 32'd868, "midframe_rst_baud");
        rd_check(4'h2, 32'h0, "midframe_rst_rxdata");
        reset = 1'b1;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
